// File: rtl/uart_cmd_rx.sv
// Two-byte command receiver: 8N1 UART bit receiver feeding a hi/lo byte assembler
// that publishes a 16-bit command with a sticky ready flag and inter-byte timeout.
module uart_cmd_rx #(
  parameter int BAUD_DIV = 2604,
  parameter int BYTE_TMO = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  input  logic        clr_cmd_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic        frm_err
);

  localparam int                TMO_W    = $clog2(BYTE_TMO + 1);
  localparam logic [11:0]       FULL_LD  = 12'(BAUD_DIV - 1);
  localparam logic [11:0]       HALF_LD  = 12'(BAUD_DIV / 2 - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(BYTE_TMO - 1);

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_st_e;
  typedef enum logic {A_WAIT_HI, A_WAIT_LO} asm_st_e;

  logic             rx_meta_q, rx_s_q;
  bit_st_e          bit_q, bit_d;
  logic [11:0]      baud_q, baud_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             frm_err_q, frm_err_d;
  logic             byte_done;

  asm_st_e          asm_q, asm_d;
  logic [7:0]       hold_q, hold_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [15:0]      cmd_q, cmd_d;
  logic             rdy_q, rdy_d;

  // RX is asynchronous; only the second flop is ever looked at.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_q     <= B_IDLE;
      baud_q    <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      frm_err_q <= 1'b0;
    end else begin
      bit_q     <= bit_d;
      baud_q    <= baud_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      frm_err_q <= frm_err_d;
    end
  end

  // Counter is loaded with (wait - 1) so the sample lands exactly 'wait' cycles later.
  always_comb begin
    bit_d     = bit_q;
    baud_d    = baud_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    frm_err_d = 1'b0;
    unique case (bit_q)
      B_IDLE: begin
        if (!rx_s_q) begin
          bit_d  = B_START;
          baud_d = HALF_LD;
        end
      end
      B_START: begin
        if (baud_q == 12'd0) begin
          if (rx_s_q) begin
            bit_d = B_IDLE;
          end else begin
            bit_d  = B_DATA;
            baud_d = FULL_LD;
            idx_d  = 3'd0;
          end
        end else begin
          baud_d = baud_q - 12'd1;
        end
      end
      B_DATA: begin
        if (baud_q == 12'd0) begin
          shift_d[idx_q] = rx_s_q;
          baud_d         = FULL_LD;
          if (idx_q == 3'd7) bit_d = B_STOP;
          else               idx_d = idx_q + 3'd1;
        end else begin
          baud_d = baud_q - 12'd1;
        end
      end
      B_STOP: begin
        if (baud_q == 12'd0) begin
          if (rx_s_q) byte_done = 1'b1;
          else        frm_err_d = 1'b1;
          bit_d = B_IDLE;
        end else begin
          baud_d = baud_q - 12'd1;
        end
      end
      default: bit_d = B_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q  <= A_WAIT_HI;
      hold_q <= '0;
      tmo_q  <= '0;
      cmd_q  <= '0;
      rdy_q  <= 1'b0;
    end else begin
      asm_q  <= asm_d;
      hold_q <= hold_d;
      tmo_q  <= tmo_d;
      cmd_q  <= cmd_d;
      rdy_q  <= rdy_d;
    end
  end

  // Setting cmd_rdy is assigned after the clear, so completion wins over acknowledge.
  always_comb begin
    asm_d  = asm_q;
    hold_d = hold_q;
    tmo_d  = tmo_q;
    cmd_d  = cmd_q;
    rdy_d  = rdy_q & ~clr_cmd_rdy;
    unique case (asm_q)
      A_WAIT_HI: begin
        if (byte_done) begin
          hold_d = shift_q;
          tmo_d  = '0;
          asm_d  = A_WAIT_LO;
        end
      end
      A_WAIT_LO: begin
        if (byte_done) begin
          cmd_d  = {hold_q, shift_q};
          rdy_d  = 1'b1;
          hold_d = '0;
          asm_d  = A_WAIT_HI;
        end else if (frm_err_d) begin
          hold_d = '0;
          asm_d  = A_WAIT_HI;
        end else if (bit_q == B_IDLE) begin
          if (tmo_q == TMO_LAST) begin
            hold_d = '0;
            tmo_d  = '0;
            asm_d  = A_WAIT_HI;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      default: asm_d = A_WAIT_HI;
    endcase
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = rdy_q;
  assign frm_err = frm_err_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: serial frames driven on RX, command and flags checked.
`timescale 1ns/1ps
module tb_uart_cmd_rx;

  localparam int BAUD = 16;
  localparam int TMO  = 200;
  localparam int LAT  = 155;  // posedges from start-bit negedge to cmd_rdy set

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        clr = 1'b0;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        frm_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = -1;
  int fall_cyc = -1;
  int ferr_pulses = 0;
  int ferr_hi = 0;
  int p0, h0;
  logic rdy_prev = 1'b0;
  logic ferr_prev = 1'b0;

  uart_cmd_rx #(.BAUD_DIV(BAUD), .BYTE_TMO(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (rx),
    .clr_cmd_rdy (clr),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .frm_err     (frm_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Edge history of the flags, sampled mid-cycle.
  always @(negedge clk) begin
    if (cmd_rdy && !rdy_prev) rise_cyc = cyc;
    if (!cmd_rdy && rdy_prev) fall_cyc = cyc;
    if (frm_err) ferr_hi++;
    if (frm_err && !ferr_prev) ferr_pulses++;
    rdy_prev  = cmd_rdy;
    ferr_prev = frm_err;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    start_cyc = cyc;
    rx = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BAUD) @(negedge clk);
    end
    rx = stop;
    repeat (BAUD) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_cmd(input logic [7:0] hi, input logic [7:0] lo);
    send_byte(hi, 1'b1);
    send_byte(lo, 1'b1);
  endtask

  task automatic expect_cmd(input string tag, input logic [15:0] val);
    check_val({tag, "_rise"}, rise_cyc, start_cyc + LAT);
    check_val({tag, "_rdy"}, {31'd0, cmd_rdy}, 32'd1);
    check_val({tag, "_cmd"}, {16'd0, cmd}, {16'd0, val});
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    idle(3);
    check_val("rst_cmd", {16'd0, cmd}, 32'h0);
    check_val("rst_rdy", {31'd0, cmd_rdy}, 32'd0);
    check_val("rst_ferr", {31'd0, frm_err}, 32'd0);
    rst_n = 1'b1;
    idle(5);

    // Basic command, then acknowledge
    send_byte(8'h5A, 1'b1);
    check_val("first_byte_rdy", {31'd0, cmd_rdy}, 32'd0);
    send_byte(8'h3C, 1'b1);
    expect_cmd("c5a3c", 16'h5A3C);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check_val("clr_rdy", {31'd0, cmd_rdy}, 32'd0);
    check_val("clr_cmd_hold", {16'd0, cmd}, 32'h5A3C);

    // Glitch shorter than half a bit is a false start
    p0 = ferr_pulses;
    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    idle(40);
    check_val("glitch_rdy", {31'd0, cmd_rdy}, 32'd0);
    check_val("glitch_ferr", ferr_pulses - p0, 32'd0);
    check_val("glitch_cmd", {16'd0, cmd}, 32'h5A3C);
    send_cmd(8'h12, 8'h34);
    expect_cmd("c1234", 16'h1234);

    // Framing error on a first byte
    pulse_clr();
    p0 = ferr_pulses;
    h0 = ferr_hi;
    send_byte(8'hFF, 1'b0);
    idle(20);
    check_val("ferr_pulses", ferr_pulses - p0, 32'd1);
    check_val("ferr_width", ferr_hi - h0, 32'd1);
    check_val("ferr_rdy", {31'd0, cmd_rdy}, 32'd0);
    send_cmd(8'hA5, 8'h0F);
    expect_cmd("ca50f", 16'hA50F);

    // Framing error on a second byte drops the held first byte
    pulse_clr();
    send_byte(8'h11, 1'b1);
    send_byte(8'hEE, 1'b0);
    idle(20);
    check_val("ferr_lo_rdy", {31'd0, cmd_rdy}, 32'd0);
    send_cmd(8'h22, 8'h33);
    expect_cmd("c2233", 16'h2233);

    // Inter-byte timeout discards 0xAA
    pulse_clr();
    send_byte(8'hAA, 1'b1);
    idle(250);
    check_val("tmo_rdy", {31'd0, cmd_rdy}, 32'd0);
    send_cmd(8'h01, 8'h02);
    expect_cmd("c0102", 16'h0102);

    // Acknowledge held across completion: set wins, then clears
    pulse_clr();
    send_byte(8'hC3, 1'b1);
    clr = 1'b1;
    send_byte(8'h3C, 1'b1);
    check_val("setwin_rise", rise_cyc, start_cyc + LAT);
    check_val("setwin_fall", fall_cyc, start_cyc + LAT + 1);
    check_val("setwin_cmd", {16'd0, cmd}, 32'hC33C);
    check_val("setwin_rdy_after", {31'd0, cmd_rdy}, 32'd0);
    clr = 1'b0;
    idle(5);

    // Reset during bit 4 of the second byte
    fork
      begin
        send_byte(8'h55, 1'b1);
        send_byte(8'h77, 1'b1);
      end
      begin
        idle(10 * BAUD + 5 * BAUD + BAUD / 2);
        rst_n = 1'b0;
        #1;
        check_val("midrst_cmd", {16'd0, cmd}, 32'h0);
        check_val("midrst_rdy", {31'd0, cmd_rdy}, 32'd0);
        check_val("midrst_ferr", {31'd0, frm_err}, 32'd0);
      end
    join
    idle(5);
    rst_n = 1'b1;
    idle(10);
    send_cmd(8'h80, 8'h01);
    expect_cmd("c8001", 16'h8001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
